exception_redirect_ctrl: RTL and testbench

//  Sequences precise exception entry and ERET return once commit has a resolved exception_info_t.

---
 rtl/exception_pkg.sv | 41 ++++
 rtl/exc_vector_calc.sv | 29 ++
 rtl/exception_redirect_ctrl.sv | 134 +++++++++++++
 tb/tb_exception_redirect_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exception_pkg.sv
// rtl/exception_pkg.sv - shared types and vector constants for exception entry/return sequencing
package exception_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DRAIN,
        REDIR
    } redirect_state_t;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        in_delay_slot;
        exc_code_t   code;
        logic [31:0] badvaddr;
    } exception_info_t;

    localparam logic [31:0] VEC_GENERAL_OFF = 32'h0000_0180;
    localparam logic [31:0] VEC_REFILL_OFF  = 32'h0000_0000;
    localparam logic [31:0] KSEG0_BASE      = 32'h8000_0000;
    localparam logic [31:0] BEV_VEC_OFF     = 32'h0000_0200;

    // A faulting delay-slot instruction restarts at its branch.
    function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_vector_calc.sv
// rtl/exc_vector_calc.sv - combinational EPC and redirect-target selection
module exc_vector_calc
    import exception_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        is_exc_i,
    input  logic [31:0] pc_i,
    input  logic        in_delay_slot_i,
    input  logic        tlb_refill_i,
    input  logic        exl_i,
    input  logic        bev_i,
    input  logic [31:0] eret_epc_i,
    output logic [31:0] epc_o,
    output logic [31:0] target_o
);

    logic [31:0] base;
    logic [31:0] offset;

    // Nested refills (EXL already set) go through the general vector.
    always_comb begin
        base     = bev_i ? (RESET_PC + BEV_VEC_OFF) : KSEG0_BASE;
        offset   = (tlb_refill_i && !exl_i) ? VEC_REFILL_OFF : VEC_GENERAL_OFF;
        epc_o    = exc_epc(pc_i, in_delay_slot_i);
        target_o = is_exc_i ? (base + offset) : eret_epc_i;
    end

endmodule

// File: rtl/exception_redirect_ctrl.sv
// rtl/exception_redirect_ctrl.sv - exception entry / ERET sequencer: CP0 write, flush, drain, redirect
module exception_redirect_ctrl
    import exception_pkg::*;
#(
    parameter int          DRAIN_MAX = 16,
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            exc_valid,
    input  exception_info_t exc_info,
    input  logic            exc_tlb_refill,
    input  logic            is_eret,
    input  logic            cp0_status_exl,
    input  logic            cp0_status_bev,
    input  logic [31:0]     cp0_epc,
    input  logic            pipe_empty,
    input  logic            redirect_ready,
    output logic            busy,
    output logic            flush,
    output logic            cp0_wr,
    output logic            cp0_wr_eret,
    output logic [31:0]     cp0_epc_w,
    output logic            cp0_bd_w,
    output logic [4:0]      cp0_code_w,
    output logic [31:0]     cp0_badvaddr_w,
    output logic            redirect_valid,
    output logic [31:0]     redirect_pc
);

    localparam int            CW         = $clog2(DRAIN_MAX + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

    redirect_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            flush_q;
    logic            cp0_wr_q;
    logic            cp0_wr_eret_q;
    logic [31:0]     epc_w_q;
    logic            bd_w_q;
    exc_code_t       code_w_q;
    logic [31:0]     badvaddr_w_q;
    logic            redirect_valid_q;
    logic [31:0]     redirect_pc_q;

    logic            start;
    logic [31:0]     vec_epc;
    logic [31:0]     vec_target;

    assign start = (state_q == IDLE) && (exc_valid || is_eret);

    exc_vector_calc #(
        .RESET_PC (RESET_PC)
    ) u_vec (
        .is_exc_i        (exc_valid),
        .pc_i            (exc_info.pc),
        .in_delay_slot_i (exc_info.in_delay_slot),
        .tlb_refill_i    (exc_tlb_refill),
        .exl_i           (cp0_status_exl),
        .bev_i           (cp0_status_bev),
        .eret_epc_i      (cp0_epc),
        .epc_o           (vec_epc),
        .target_o        (vec_target)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = WRITE;
            end
            WRITE: begin
                state_d = DRAIN;
                cnt_d   = '0;
            end
            DRAIN: begin
                if (pipe_empty || (cnt_q == DRAIN_LAST)) state_d = REDIR;
                else                                     cnt_d   = cnt_q + CW'(1);
            end
            REDIR: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes fire in the WRITE cycle; everything is captured at request time so
    // later CP0 changes cannot disturb the in-flight sequence.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            flush_q          <= 1'b0;
            cp0_wr_q         <= 1'b0;
            cp0_wr_eret_q    <= 1'b0;
            epc_w_q          <= '0;
            bd_w_q           <= 1'b0;
            code_w_q         <= EXC_INT;
            badvaddr_w_q     <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            flush_q          <= start;
            cp0_wr_q         <= start && exc_valid && !cp0_status_exl;
            cp0_wr_eret_q    <= start && !exc_valid;
            redirect_valid_q <= (state_d == REDIR);
            if (start) begin
                redirect_pc_q <= vec_target;
            end
            if (start && exc_valid) begin
                epc_w_q      <= vec_epc;
                bd_w_q       <= exc_info.in_delay_slot;
                code_w_q     <= exc_info.code;
                badvaddr_w_q <= exc_info.badvaddr;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign flush          = flush_q;
    assign cp0_wr         = cp0_wr_q;
    assign cp0_wr_eret    = cp0_wr_eret_q;
    assign cp0_epc_w      = epc_w_q;
    assign cp0_bd_w       = bd_w_q;
    assign cp0_code_w     = code_w_q;
    assign cp0_badvaddr_w = badvaddr_w_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
// tb/tb_exception_redirect_ctrl.sv - self-checking bench for exception_redirect_ctrl
module tb_exception_redirect_ctrl;
    import exception_pkg::*;

    localparam int DRAIN_MAX = 16;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            exc_valid = 1'b0;
    exception_info_t exc_info;
    logic            exc_tlb_refill = 1'b0;
    logic            is_eret = 1'b0;
    logic            cp0_status_exl = 1'b0;
    logic            cp0_status_bev = 1'b0;
    logic [31:0]     cp0_epc = '0;
    logic            pipe_empty = 1'b0;
    logic            redirect_ready = 1'b0;
    logic            busy, flush, cp0_wr, cp0_wr_eret, cp0_bd_w, redirect_valid;
    logic [31:0]     cp0_epc_w, cp0_badvaddr_w, redirect_pc;
    logic [4:0]      cp0_code_w;

    always #5 clk = ~clk;

    exception_redirect_ctrl #(
        .DRAIN_MAX (DRAIN_MAX),
        .RESET_PC  (32'hBFC0_0000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .exc_valid      (exc_valid),
        .exc_info       (exc_info),
        .exc_tlb_refill (exc_tlb_refill),
        .is_eret        (is_eret),
        .cp0_status_exl (cp0_status_exl),
        .cp0_status_bev (cp0_status_bev),
        .cp0_epc        (cp0_epc),
        .pipe_empty     (pipe_empty),
        .redirect_ready (redirect_ready),
        .busy           (busy),
        .flush          (flush),
        .cp0_wr         (cp0_wr),
        .cp0_wr_eret    (cp0_wr_eret),
        .cp0_epc_w      (cp0_epc_w),
        .cp0_bd_w       (cp0_bd_w),
        .cp0_code_w     (cp0_code_w),
        .cp0_badvaddr_w (cp0_badvaddr_w),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic        exc;
        logic        eret;
        logic [31:0] pc;
        logic        ds;
        logic [4:0]  code;
        logic [31:0] badv;
        logic        refill;
        logic        exl;
        logic        bev;
        logic [31:0] epc;
        int          d;
        int          r;
        logic        x_wr;
        logic        x_eret;
        logic [31:0] x_epc;
        logic        x_bd;
        logic [31:0] x_pc;
        int          x_drain;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic exc, input logic eret, input logic [31:0] pc, input logic ds,
                                input logic [4:0] code, input logic [31:0] badv, input logic refill,
                                input logic exl, input logic bev, input logic [31:0] epc, input int d, input int r);
        vec_t v;
        v.exc = exc; v.eret = eret; v.pc = pc; v.ds = ds; v.code = code; v.badv = badv;
        v.refill = refill; v.exl = exl; v.bev = bev; v.epc = epc; v.d = d; v.r = r;
        v.x_wr = 0; v.x_eret = 0; v.x_epc = 0; v.x_bd = 0; v.x_pc = 0; v.x_drain = 0;
        return v;
    endfunction

    function automatic vec_t with_exp(input vec_t v, input logic wr, input logic eret, input logic [31:0] epc,
                                      input logic bd, input logic [31:0] pc, input int drain);
        vec_t o = v;
        o.x_wr = wr; o.x_eret = eret; o.x_epc = epc; o.x_bd = bd; o.x_pc = pc; o.x_drain = drain;
        return o;
    endfunction

    // Reference: exception beats ERET; EXL=1 suppresses the CP0 write and the refill vector;
    // the pipe drains after d busy cycles but never longer than DRAIN_MAX.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        longint vec;
        o.x_wr   = v.exc && !v.exl;
        o.x_eret = !v.exc && v.eret;
        o.x_bd   = v.ds;
        o.x_epc  = 32'((longint'(v.pc) + 64'h1_0000_0000 - (v.ds ? 4 : 0)) % 64'h1_0000_0000);
        vec      = (v.bev ? 64'hBFC0_0000 + 64'h200 : 64'h8000_0000) + ((v.refill && !v.exl) ? 0 : 64'h180);
        o.x_pc   = v.exc ? 32'(vec) : v.epc;
        o.x_drain = (v.d + 1 < DRAIN_MAX) ? v.d + 1 : DRAIN_MAX;
        return o;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int  ncyc;
        bit  seen;
        @(negedge clk);
        check(tag, "busy_idle", busy, 0);
        exc_valid              = v.exc;
        is_eret                = v.eret;
        exc_info.pc            = v.pc;
        exc_info.in_delay_slot = v.ds;
        exc_info.code          = exc_code_t'(v.code);
        exc_info.badvaddr      = v.badv;
        exc_tlb_refill         = v.refill;
        cp0_status_exl         = v.exl;
        cp0_status_bev         = v.bev;
        cp0_epc                = v.epc;
        pipe_empty             = 1'b0;
        redirect_ready         = 1'b0;
        @(negedge clk);
        exc_valid      = 1'b0;
        is_eret        = 1'b0;
        cp0_status_exl = 1'($urandom);
        cp0_status_bev = 1'($urandom);
        cp0_epc        = $urandom;
        exc_info.pc    = $urandom;
        exc_tlb_refill = 1'($urandom);
        check(tag, "busy_write", busy, 1);
        check(tag, "flush", flush, 1);
        check(tag, "cp0_wr", cp0_wr, v.x_wr);
        check(tag, "cp0_wr_eret", cp0_wr_eret, v.x_eret);
        if (v.x_wr) begin
            check(tag, "epc_w", cp0_epc_w, v.x_epc);
            check(tag, "bd_w", cp0_bd_w, v.x_bd);
            check(tag, "code_w", cp0_code_w, v.code);
            check(tag, "badvaddr_w", cp0_badvaddr_w, v.badv);
        end
        ncyc = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check(tag, "flush_pulse", flush, 0);
                check(tag, "cp0_wr_pulse", cp0_wr, 0);
                check(tag, "eret_pulse", cp0_wr_eret, 0);
                check(tag, "busy_drain", busy, 1);
            end
            if (redirect_valid) seen = 1;
            else begin
                pipe_empty = (ncyc >= v.d);
                is_eret    = 1'($urandom);
                ncyc++;
            end
        end
        check(tag, "redirect_seen", 32'(seen), 1);
        check(tag, "drain_cycles", ncyc, v.x_drain);
        check(tag, "redirect_pc", redirect_pc, v.x_pc);
        for (int j = 0; j < v.r; j++) begin
            @(negedge clk);
            check(tag, "valid_hold", redirect_valid, 1);
            check(tag, "pc_hold", redirect_pc, v.x_pc);
        end
        redirect_ready = 1'b1;
        is_eret        = 1'b0;
        exc_valid      = 1'b0;
        @(negedge clk);
        redirect_ready = 1'b0;
        pipe_empty     = 1'b0;
        check(tag, "busy_after", busy, 0);
        check(tag, "valid_after", redirect_valid, 0);
    endtask

    vec_t tbl[8];
    vec_t rv;
    bit   seen_r;

    initial begin
        exc_info = '0;
        repeat (2) @(negedge clk);
        check("reset", "busy", busy, 0);
        check("reset", "flush", flush, 0);
        check("reset", "cp0_wr", cp0_wr, 0);
        check("reset", "cp0_wr_eret", cp0_wr_eret, 0);
        check("reset", "redirect_valid", redirect_valid, 0);
        check("reset", "redirect_pc", redirect_pc, 0);
        resetn = 1'b1;

        tbl[0] = with_exp(mk(1, 0, 32'h8000_1000, 0, EXC_SYS, 32'h0, 0, 0, 0, 32'h0, 0, 0),
                          1, 0, 32'h8000_1000, 0, 32'h8000_0180, 1);
        tbl[1] = with_exp(mk(1, 0, 32'h8000_2004, 1, EXC_TLBL, 32'h1234_5678, 1, 0, 1, 32'h0, 2, 1),
                          1, 0, 32'h8000_2000, 1, 32'hBFC0_0200, 3);
        tbl[2] = with_exp(mk(1, 0, 32'h8000_2004, 1, EXC_TLBL, 32'h1234_5678, 1, 1, 0, 32'h0, 0, 0),
                          0, 0, 32'h0, 0, 32'h8000_0180, 1);
        tbl[3] = with_exp(mk(0, 1, 32'h0, 0, EXC_INT, 32'h0, 0, 1, 0, 32'h8000_3000, 1, 0),
                          0, 1, 32'h0, 0, 32'h8000_3000, 2);
        tbl[4] = with_exp(mk(1, 1, 32'h8000_4000, 0, EXC_BP, 32'h0, 0, 0, 0, 32'h8000_3000, 0, 2),
                          1, 0, 32'h8000_4000, 0, 32'h8000_0180, 1);
        tbl[5] = with_exp(mk(1, 0, 32'h8000_5000, 0, EXC_OV, 32'h0, 0, 0, 0, 32'h0, 1000, 5),
                          1, 0, 32'h8000_5000, 0, 32'h8000_0180, 16);
        tbl[6] = with_exp(mk(1, 0, 32'h0000_0000, 1, EXC_ADEL, 32'hFFFF_FFFF, 0, 0, 1, 32'h0, 15, 0),
                          1, 0, 32'hFFFF_FFFC, 1, 32'hBFC0_0380, 16);
        tbl[7] = with_exp(mk(0, 1, 32'h0, 0, EXC_INT, 32'h0, 0, 1, 1, 32'h9000_0000, 14, 1),
                          0, 1, 32'h0, 0, 32'h9000_0000, 15);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset while a redirect is pending must drop it cleanly.
        @(negedge clk);
        exc_valid = 1'b1; exc_info.pc = 32'h8000_7000; exc_info.in_delay_slot = 1'b0;
        exc_info.code = EXC_SYS; cp0_status_exl = 1'b0; cp0_status_bev = 1'b0;
        pipe_empty = 1'b1; redirect_ready = 1'b0;
        @(negedge clk);
        exc_valid = 1'b0;
        seen_r = 0;
        for (int i = 0; i < 10 && !seen_r; i++) begin
            @(negedge clk);
            if (redirect_valid) seen_r = 1;
        end
        check("rst_mid", "reached_redir", 32'(seen_r), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid", "busy", busy, 0);
        check("rst_mid", "redirect_valid", redirect_valid, 0);
        check("rst_mid", "flush", flush, 0);
        check("rst_mid", "cp0_wr", cp0_wr, 0);
        check("rst_mid", "cp0_wr_eret", cp0_wr_eret, 0);
        resetn = 1'b1;
        pipe_empty = 1'b0;
        @(negedge clk);
        check("rst_mid", "busy_idle", busy, 0);
        run_txn(tbl[0], "post_reset");

        for (int n = 0; n < 30; n++) begin
            rv = mk(1'($urandom), 1'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom,
                    1'($urandom), 1'($urandom), 1'($urandom), $urandom,
                    $urandom_range(0, 18), $urandom_range(0, 3));
            if (!rv.exc && !rv.eret) rv.eret = 1'b1;
            run_txn(model(rv), $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
